microwave_mode_fsm: RTL and testbench
=====================================

Name: microwave_mode_fsm

Overview:
- Mode sequencer for the microwave function; drives the 3-bit `mode` bus consumed by the run-time button controller.
- That controller adjusts `run_time` in SET and counts it down in RUN.
- This block takes debounced button pulses, the door switch and the live `run_time`, and decides IDLE/SET/RUN/STOP/FINISH.
- It also generates the end-of-cook done pulse and buzzer drive.

Parameters:
- FINISH_CYCLES, 300_000_000: clocks spent in FINISH before returning to IDLE (3 s at 100 MHz).
- BEEP_HALF_CYCLES, 25_000_000: half-period of the buzzer square wave (2 Hz).
- CNT_W, 29: width of the internal FINISH/beep counters; must hold FINISH_CYCLES-1.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- btnC  input  1  start/pause; single-cycle debounced pulse.
- btnL  input  1  cancel; single-cycle debounced pulse.
- btnU  input  1  time-up request; single-cycle pulse, used only to leave IDLE.
- btnD  input  1  time-down request; single-cycle pulse, used only to leave IDLE.
- door_open  input  1  level; 1 = door open (synchronised upstream).
- run_time  input  14  remaining seconds from the run-time controller.
- mode  output  3  IDLE=000, SET=001, RUN=010, STOP=011, FINISH=100.
- running  output  1  1 while mode==RUN (magnetron/lamp enable).
- done_pulse  output  1  one-cycle pulse on entry to FINISH.
- beep  output  1  buzzer drive, toggling square wave in FINISH, else 0.

Behaviour:
- Reset: interface is one clock (`clk`); `reset` is asynchronous and active-high.
  - While reset is asserted: mode=IDLE, running=0, done_pulse=0, beep=0, all counters 0.
- Registered Moore FSM. Inputs sampled at a rising edge take effect on `mode` at that edge (one-cycle latency).
- Button pulses are mutually independent. When several are asserted in the same cycle, btnL has priority over btnC, and btnC over btnU/btnD.
- IDLE:
  - btnU or btnD -> SET.
  - btnC or btnL -> stay in IDLE.
- SET:
  - btnL -> IDLE.
  - btnC with run_time!=0 and door_open==0 -> RUN.
  - btnC with run_time==0 or door_open==1 -> stay in SET.
  - btnU/btnD -> stay in SET (the downstream controller applies them).
- RUN:
  - run_time==0 -> FINISH. This check has priority over all buttons.
  - Else door_open==1 -> STOP.
  - Else btnC or btnL -> STOP.
  - btnU/btnD are ignored.
- STOP:
  - btnL -> SET, so the user can re-adjust the time.
  - btnC with run_time!=0 and door_open==0 -> RUN.
  - btnC with run_time==0 -> IDLE.
  - Otherwise hold in STOP.
- FINISH:
  - On entry, fin_cnt=0 and beep=1.
  - fin_cnt increments every cycle.
  - beep toggles every BEEP_HALF_CYCLES cycles, counted from entry.
  - fin_cnt==FINISH_CYCLES-1 -> IDLE.
  - Any of btnC/btnL/btnU/btnD, or door_open rising, -> IDLE early.
  - beep is 0 in the cycle `mode` becomes IDLE.
- Outputs:
  - done_pulse is high exactly in the first cycle mode==FINISH. It is registered alongside the transition.
  - running equals (mode==RUN) and is registered; it never glitches.
- Counters:
  - Counters use CNT_W-bit unsigned arithmetic.
  - fin_cnt never wraps, because the state is left at FINISH_CYCLES-1.
  - The beep counter resets to 0 on each toggle.
- Reset mid-RUN or mid-FINISH: immediate return to IDLE with beep=0. run_time is owned by the neighbouring block and is not touched here.
- Illegal state encodings (101–111) -> IDLE on the next edge.

Decomposition:
- Shared package/header `microwave_pkg` holds the mode encodings IDLE/SET/RUN/STOP/FINISH. The run-time controller uses these same encodings, so both blocks must take them from the package.
- One natural sub-module, `beep_gen`: takes an enable plus the half-period parameter and produces a square wave with a reset-on-enable counter. The FSM instantiates it with enable = (mode==FINISH).

Test Plan (sim with FINISH_CYCLES=20, BEEP_HALF_CYCLES=4):
- Normal cook:
  - Stimulus: reset, then btnU with run_time driven 0->30, then btnC with door_open=0.
  - Required: mode 000->001->010.
  - Then drive run_time to 0: mode=100 on the next edge, done_pulse high for exactly 1 cycle, beep toggles every 4 cycles, mode=000 after 20 cycles, beep=0.
- Pause/resume:
  - Stimulus: in RUN with run_time=25, pulse btnC; then pulse btnC again.
  - Required: mode=011 with running=0 after the first pulse; mode=010 with running=1 after the second.
- Door interlock:
  - Stimulus: in RUN, raise door_open; then pulse btnC while door_open=1.
  - Required: mode=011 after the door opens, and mode stays 011 after btnC.
  - Then lower door_open and pulse btnC: mode=010.
- Priority/boundaries:
  - btnC+btnL in the same cycle while in RUN with run_time=10 -> STOP.
  - btnC+btnL in the same cycle while in SET -> IDLE.
  - btnC in SET with run_time=0 -> stays 001.
  - run_time=0 and btnC in the same RUN cycle -> FINISH.
- Early exit and reset:
  - btnD at the 5th cycle of FINISH -> IDLE, beep=0.
  - Async reset asserted mid-RUN (not on a clock edge) -> mode=000, running=0 immediately.

Source files
------------

// File: rtl/microwave_pkg.sv
// Mode encodings shared by the microwave mode sequencer and the run-time
// button controller, so both sides decode the mode bus identically.
package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        SET    = 3'b001,
        RUN    = 3'b010,
        STOP   = 3'b011,
        FINISH = 3'b100
    } mode_e;

    localparam int RUN_TIME_W = 14;

    // A cook may start only with time left and the door shut.
    function automatic logic start_ok(input logic [RUN_TIME_W-1:0] rt,
                                      input logic                  door);
        return (rt != '0) && !door;
    endfunction

endpackage

// File: rtl/microwave_mode_fsm_if.sv
// Button/door/run-time inputs and mode/status outputs of the mode sequencer.
interface microwave_mode_fsm_if;
    import microwave_pkg::*;

    logic                  btnC;
    logic                  btnL;
    logic                  btnU;
    logic                  btnD;
    logic                  door_open;
    logic [RUN_TIME_W-1:0] run_time;
    logic [2:0]            mode;
    logic                  running;
    logic                  done_pulse;
    logic                  beep;

    modport master (
        output btnC, btnL, btnU, btnD, door_open, run_time,
        input  mode, running, done_pulse, beep
    );

    modport slave (
        input  btnC, btnL, btnU, btnD, door_open, run_time,
        output mode, running, done_pulse, beep
    );

endinterface

// File: rtl/microwave_mode_fsm_beep_gen.sv
// Buzzer square-wave generator: high for the first half-period after enable,
// then toggles every HALF_CYCLES clocks; held at 0 while disabled.
module beep_gen #(
    parameter int HALF_CYCLES = 25_000_000,
    parameter int CNT_W       = 29
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic beep
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == HALF_LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Gating with en makes beep rise in the very first enabled cycle.
    assign beep = en & ~phase;

endmodule

// File: rtl/microwave_mode_fsm.sv
// Microwave mode sequencer: IDLE/SET/RUN/STOP/FINISH Moore FSM with
// registered running/done_pulse outputs and the FINISH buzzer.
module microwave_mode_fsm
    import microwave_pkg::*;
#(
    parameter int FINISH_CYCLES    = 300_000_000,
    parameter int BEEP_HALF_CYCLES = 25_000_000,
    parameter int CNT_W            = 29
) (
    input  logic                 clk,
    input  logic                 reset,
    microwave_mode_fsm_if.slave  bus
);

    localparam logic [CNT_W-1:0] FIN_LAST = CNT_W'(FINISH_CYCLES - 1);

    mode_e            mode_q;
    mode_e            nxt;
    logic             running_q;
    logic             done_q;
    logic             door_q;
    logic [CNT_W-1:0] fin_cnt;
    logic             any_btn;
    logic             door_rise;

    assign any_btn   = bus.btnC | bus.btnL | bus.btnU | bus.btnD;
    assign door_rise = bus.door_open & ~door_q;

    always_comb begin
        nxt = mode_q;
        case (mode_q)
            IDLE: begin
                if (!bus.btnL && !bus.btnC && (bus.btnU || bus.btnD))
                    nxt = SET;
            end
            SET: begin
                if (bus.btnL)
                    nxt = IDLE;
                else if (bus.btnC && start_ok(bus.run_time, bus.door_open))
                    nxt = RUN;
            end
            RUN: begin
                // Running out of time wins over the door and every button.
                if (bus.run_time == '0)
                    nxt = FINISH;
                else if (bus.door_open || bus.btnC || bus.btnL)
                    nxt = STOP;
            end
            STOP: begin
                if (bus.btnL)
                    nxt = SET;
                else if (bus.btnC) begin
                    if (bus.run_time == '0)
                        nxt = IDLE;
                    else if (!bus.door_open)
                        nxt = RUN;
                end
            end
            FINISH: begin
                if (fin_cnt == FIN_LAST || any_btn || door_rise)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            door_q    <= 1'b0;
            fin_cnt   <= '0;
        end else begin
            mode_q    <= nxt;
            running_q <= (nxt == RUN);
            done_q    <= (nxt == FINISH) && (mode_q != FINISH);
            door_q    <= bus.door_open;
            // Counter restarts at 0 on every entry and stops at FIN_LAST.
            if (mode_q == FINISH && nxt == FINISH)
                fin_cnt <= fin_cnt + CNT_W'(1);
            else
                fin_cnt <= '0;
        end
    end

    beep_gen #(
        .HALF_CYCLES (BEEP_HALF_CYCLES),
        .CNT_W       (CNT_W)
    ) u_beep_gen (
        .clk   (clk),
        .reset (reset),
        .en    (mode_q == FINISH),
        .beep  (bus.beep)
    );

    assign bus.mode       = mode_q;
    assign bus.running    = running_q;
    assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_microwave_mode_fsm.sv
// Directed bench for the microwave mode sequencer with short FINISH/beep timing.
module tb_microwave_mode_fsm;

    localparam int FC = 20;
    localparam int BH = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    microwave_mode_fsm_if bus ();

    microwave_mode_fsm #(
        .FINISH_CYCLES    (FC),
        .BEEP_HALF_CYCLES (BH),
        .CNT_W            (29)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic c, input logic l, input logic u, input logic d);
        bus.btnC = c;
        bus.btnL = l;
        bus.btnU = u;
        bus.btnD = d;
        tick();
        bus.btnC = 1'b0;
        bus.btnL = 1'b0;
        bus.btnU = 1'b0;
        bus.btnD = 1'b0;
    endtask

    // From IDLE, go to SET with btnU then start the cook with btnC.
    task automatic go_run(input logic [13:0] rt);
        bus.run_time = rt;
        press(0, 0, 1, 0);
        check_eq("go_set", bus.mode, 3'b001);
        press(1, 0, 0, 0);
        check_eq("go_run", bus.mode, 3'b010);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.btnC = 1'b0;
        bus.btnL = 1'b0;
        bus.btnU = 1'b0;
        bus.btnD = 1'b0;
        bus.door_open = 1'b0;
        bus.run_time  = 14'd0;
        tick();
        tick();
        check_eq("rst_mode", bus.mode, 3'b000);
        check_eq("rst_running", bus.running, 1'b0);
        check_eq("rst_done", bus.done_pulse, 1'b0);
        check_eq("rst_beep", bus.beep, 1'b0);
        reset = 1'b0;
        tick();

        // IDLE ignores start and cancel
        press(1, 0, 0, 0);
        check_eq("idle_btnC", bus.mode, 3'b000);
        press(0, 1, 0, 0);
        check_eq("idle_btnL", bus.mode, 3'b000);

        // Normal cook with full FINISH interval
        go_run(14'd30);
        check_eq("cook_running", bus.running, 1'b1);
        bus.run_time = 14'd0;
        tick();
        check_eq("fin_mode", bus.mode, 3'b100);
        check_eq("fin_done", bus.done_pulse, 1'b1);
        check_eq("fin_running", bus.running, 1'b0);
        check_eq("fin_beep0", bus.beep, 1'b1);
        for (int k = 1; k < FC; k++) begin
            tick();
            check_eq("fin_hold", bus.mode, 3'b100);
            check_eq("fin_beep", bus.beep, ((k / BH) % 2 == 0) ? 1'b1 : 1'b0);
            if (k == 1) check_eq("fin_done_once", bus.done_pulse, 1'b0);
        end
        tick();
        check_eq("fin_exit_mode", bus.mode, 3'b000);
        check_eq("fin_exit_beep", bus.beep, 1'b0);

        // Pause / resume
        go_run(14'd25);
        press(1, 0, 0, 0);
        check_eq("pause_mode", bus.mode, 3'b011);
        check_eq("pause_running", bus.running, 1'b0);
        press(1, 0, 0, 0);
        check_eq("resume_mode", bus.mode, 3'b010);
        check_eq("resume_running", bus.running, 1'b1);

        // Door interlock
        bus.door_open = 1'b1;
        tick();
        check_eq("door_stop", bus.mode, 3'b011);
        press(1, 0, 0, 0);
        check_eq("door_btnC_hold", bus.mode, 3'b011);
        bus.door_open = 1'b0;
        tick();
        check_eq("door_closed_hold", bus.mode, 3'b011);
        press(1, 0, 0, 0);
        check_eq("door_resume", bus.mode, 3'b010);

        // Priority and boundaries
        bus.run_time = 14'd10;
        press(1, 1, 0, 0);
        check_eq("run_CL_stop", bus.mode, 3'b011);
        press(0, 1, 0, 0);
        check_eq("stop_L_set", bus.mode, 3'b001);
        press(1, 1, 0, 0);
        check_eq("set_CL_idle", bus.mode, 3'b000);
        press(0, 0, 1, 0);
        check_eq("idle_U_set", bus.mode, 3'b001);
        bus.run_time = 14'd0;
        press(1, 0, 0, 0);
        check_eq("set_zero_hold", bus.mode, 3'b001);
        bus.run_time = 14'd10;
        press(1, 0, 0, 0);
        check_eq("set_C_run", bus.mode, 3'b010);
        bus.run_time = 14'd0;
        press(1, 0, 0, 0);
        check_eq("run_zero_C_fin", bus.mode, 3'b100);
        check_eq("run_zero_C_done", bus.done_pulse, 1'b1);

        // Early exit with btnD in the 5th FINISH cycle
        for (int k = 1; k < 5; k++) tick();
        check_eq("early_mode", bus.mode, 3'b100);
        check_eq("early_beep", bus.beep, 1'b0);
        press(0, 0, 0, 1);
        check_eq("early_exit_mode", bus.mode, 3'b000);
        check_eq("early_exit_beep", bus.beep, 1'b0);

        // Early exit on door opening during FINISH
        go_run(14'd5);
        bus.run_time = 14'd0;
        tick();
        check_eq("door_fin_mode", bus.mode, 3'b100);
        tick();
        bus.door_open = 1'b1;
        tick();
        check_eq("door_fin_exit", bus.mode, 3'b000);
        bus.door_open = 1'b0;
        tick();

        // STOP with no time left returns to IDLE
        go_run(14'd7);
        press(1, 0, 0, 0);
        check_eq("stop2_mode", bus.mode, 3'b011);
        bus.run_time = 14'd0;
        press(1, 0, 0, 0);
        check_eq("stop_zero_idle", bus.mode, 3'b000);

        // Asynchronous reset between clock edges during RUN
        go_run(14'd30);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_mode", bus.mode, 3'b000);
        check_eq("async_running", bus.running, 1'b0);
        check_eq("async_beep", bus.beep, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("post_rst_mode", bus.mode, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
